// File: rtl/gray_seq_monitor.sv
// Gray-code sequence sink: 2-stage Gray-to-binary pipeline with step checking,
// direction/wrap reporting and a saturating step-error counter.
module gray_seq_monitor #(
  parameter int W         = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 g_valid,
  input  logic [W-1:0]         g_in,
  input  logic                 err_clr,
  output logic [W-1:0]         b_out,
  output logic                 b_valid,
  output logic                 step_ok,
  output logic                 step_err,
  output logic                 dir_up,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {S_FIRST = 1'b0, S_TRACK = 1'b1} state_t;

  localparam logic [W-1:0]         ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]         ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]         ALL1_W   = {W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ZERO_CNT = {ERR_CNT_W{1'b0}};
  localparam logic [ERR_CNT_W-1:0] ONE_CNT  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] MAX_CNT  = {ERR_CNT_W{1'b1}};

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b        = ZERO_W;
    b[W-1]   = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t                 state_q, state_d;
  logic [W-1:0]           g_q;
  logic                   v1_q;
  logic [W-1:0]           b_prev_q;
  logic [W-1:0]           b_out_q;
  logic                   b_valid_q, step_ok_q, step_err_q, dir_up_q, wrap_q;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic [W-1:0]           b_new_s, diff_s;
  logic                   step_ok_d, step_err_d, dir_up_d, wrap_d;

  assign b_new_s = gray2bin(g_q);
  assign diff_s  = b_new_s - b_prev_q;

  // Stage 1: capture the Gray sample
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q  <= ZERO_W;
      v1_q <= 1'b0;
    end else begin
      v1_q <= g_valid;
      if (g_valid) g_q <= g_in;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FIRST;
    else     state_q <= state_d;
  end

  // FSM next state: leave FIRST once a sample reaches stage 2
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FIRST: begin
        if (v1_q) state_d = S_TRACK;
        else      state_d = S_FIRST;
      end
      S_TRACK: state_d = S_TRACK;
      default: state_d = S_FIRST;
    endcase
  end

  // FSM outputs: classify the modular step against the previous sample
  always_comb begin
    step_ok_d  = 1'b0;
    step_err_d = 1'b0;
    dir_up_d   = 1'b0;
    wrap_d     = 1'b0;
    case (state_q)
      S_TRACK: begin
        if (!v1_q) begin
          step_ok_d = 1'b0;
        end else if (diff_s == ZERO_W) begin
          step_ok_d = 1'b0;
        end else if (diff_s == ONE_W) begin
          step_ok_d = 1'b1;
          dir_up_d  = 1'b1;
          wrap_d    = (b_prev_q == ALL1_W);
        end else if (diff_s == ALL1_W) begin
          step_ok_d = 1'b1;
          wrap_d    = (b_prev_q == ZERO_W);
        end else begin
          step_err_d = 1'b1;
        end
      end
      default: step_ok_d = 1'b0;
    endcase
  end

  // Error counter: clear beats a coincident increment; saturates at all-ones
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = ZERO_CNT;
    end else if (step_err_d && (err_count_q != MAX_CNT)) begin
      err_count_d = err_count_q + ONE_CNT;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Stage 2 and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      b_out_q     <= ZERO_W;
      b_prev_q    <= ZERO_W;
      b_valid_q   <= 1'b0;
      step_ok_q   <= 1'b0;
      step_err_q  <= 1'b0;
      dir_up_q    <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= ZERO_CNT;
    end else begin
      b_valid_q   <= v1_q;
      step_ok_q   <= step_ok_d;
      step_err_q  <= step_err_d;
      dir_up_q    <= dir_up_d;
      wrap_q      <= wrap_d;
      err_count_q <= err_count_d;
      if (v1_q) begin
        b_out_q  <= b_new_s;
        b_prev_q <= b_new_s;
      end
    end
  end

  assign b_out     = b_out_q;
  assign b_valid   = b_valid_q;
  assign step_ok   = step_ok_q;
  assign step_err  = step_err_q;
  assign dir_up    = dir_up_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Directed bench for gray_seq_monitor; observed word is
// {b_valid, step_ok, step_err, dir_up, wrap, b_out}.
module tb_gray_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       g_valid = 1'b0;
  logic [3:0] g_in = 4'b0000;
  logic       err_clr = 1'b0;
  logic [3:0] b_out;
  logic       b_valid, step_ok, step_err, dir_up, wrap;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  gray_seq_monitor #(.W(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g_in(g_in), .err_clr(err_clr),
    .b_out(b_out), .b_valid(b_valid), .step_ok(step_ok), .step_err(step_err),
    .dir_up(dir_up), .wrap(wrap), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {b_valid, step_ok, step_err, dir_up, wrap, b_out};
  endfunction

  task automatic tick(input logic v, input logic [3:0] g, input logic clr);
    g_valid = v;
    g_in    = g;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(1'b1, 4'b0101, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (obs() !== 9'b0_0000_0000) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", obs(), 9'b0_0000_0000);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL reset_err_count got %0d exp 0", err_count);
    end
  endtask

  task automatic test_basic();
    reset_dut();
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b1, 4'b0001, 1'b0);
    checks++;
    if (obs() !== 9'b1_0000_0000) begin
      errors++; $display("FAIL basic_first got %b exp %b", obs(), 9'b1_0000_0000);
    end
    tick(1'b1, 4'b0011, 1'b0);
    checks++;
    if (obs() !== 9'b1_1010_0001) begin
      errors++; $display("FAIL basic_1 got %b exp %b", obs(), 9'b1_1010_0001);
    end
    tick(1'b1, 4'b0010, 1'b0);
    checks++;
    if (obs() !== 9'b1_1010_0010) begin
      errors++; $display("FAIL basic_2 got %b exp %b", obs(), 9'b1_1010_0010);
    end
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_1010_0011) begin
      errors++; $display("FAIL basic_3 got %b exp %b", obs(), 9'b1_1010_0011);
    end
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b0_0000_0011) begin
      errors++; $display("FAIL basic_idle_hold got %b exp %b", obs(), 9'b0_0000_0011);
    end
  endtask

  task automatic test_up_wrap();
    reset_dut();
    tick(1'b1, 4'b1000, 1'b0);
    tick(1'b1, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_0000_1111) begin
      errors++; $display("FAIL upwrap_first got %b exp %b", obs(), 9'b1_0000_1111);
    end
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_1011_0000) begin
      errors++; $display("FAIL upwrap_step got %b exp %b", obs(), 9'b1_1011_0000);
    end
  endtask

  task automatic test_down();
    reset_dut();
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b1, 4'b1000, 1'b0);
    tick(1'b1, 4'b0011, 1'b0);
    checks++;
    if (obs() !== 9'b1_1001_1111) begin
      errors++; $display("FAIL down_wrap got %b exp %b", obs(), 9'b1_1001_1111);
    end
    tick(1'b1, 4'b0001, 1'b0);
    checks++;
    if (obs() !== 9'b1_0100_0010) begin
      errors++; $display("FAIL down_jump_err got %b exp %b", obs(), 9'b1_0100_0010);
    end
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_1000_0001) begin
      errors++; $display("FAIL down_step got %b exp %b", obs(), 9'b1_1000_0001);
    end
    checks++;
    if (err_count !== 8'd1) begin
      errors++; $display("FAIL down_err_count got %0d exp 1", err_count);
    end
  endtask

  task automatic test_errors();
    reset_dut();
    tick(1'b1, 4'b0001, 1'b0);
    tick(1'b1, 4'b1001, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_0100_1110) begin
      errors++; $display("FAIL err_first_jump got %b exp %b", obs(), 9'b1_0100_1110);
    end
    checks++;
    if (err_count !== 8'd1) begin
      errors++; $display("FAIL err_count_1 got %0d exp 1", err_count);
    end
    // alternate binary 0 and 8: every sample is an illegal jump
    for (int i = 0; i < 100; i++) tick(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b1100, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (err_count !== 8'd101) begin
      errors++; $display("FAIL err_count_101 got %0d exp 101", err_count);
    end
    for (int i = 100; i < 300; i++) tick(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b1100, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL err_count_sat got %0d exp 255", err_count);
    end
    // 8 -> 1 is illegal; clear lands on the same edge as the increment
    tick(1'b1, 4'b0001, 1'b0);
    tick(1'b0, 4'b0000, 1'b1);
    checks++;
    if (obs() !== 9'b1_0100_0001) begin
      errors++; $display("FAIL err_clr_pulse got %b exp %b", obs(), 9'b1_0100_0001);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL err_clr_wins got %0d exp 0", err_count);
    end
    tick(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_hold_gaps();
    reset_dut();
    tick(1'b1, 4'b0011, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_0000_0010) begin
      errors++; $display("FAIL hold_first got %b exp %b", obs(), 9'b1_0000_0010);
    end
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b0_0000_0010) begin
      errors++; $display("FAIL hold_gap got %b exp %b", obs(), 9'b0_0000_0010);
    end
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b1, 4'b0011, 1'b0);
    tick(1'b1, 4'b0110, 1'b0);
    checks++;
    if (obs() !== 9'b1_0000_0010) begin
      errors++; $display("FAIL hold_same got %b exp %b", obs(), 9'b1_0000_0010);
    end
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_0100_0100) begin
      errors++; $display("FAIL hold_then_jump got %b exp %b", obs(), 9'b1_0100_0100);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    tick(1'b1, 4'b0001, 1'b0);
    rst = 1'b1;
    tick(1'b1, 4'b0011, 1'b0);
    rst = 1'b0;
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b0_0000_0000) begin
      errors++; $display("FAIL rstmid_no_valid_a got %b exp %b", obs(), 9'b0_0000_0000);
    end
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b0_0000_0000) begin
      errors++; $display("FAIL rstmid_no_valid_b got %b exp %b", obs(), 9'b0_0000_0000);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL rstmid_err_count got %0d exp 0", err_count);
    end
    tick(1'b1, 4'b0101, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    checks++;
    if (obs() !== 9'b1_0000_0110) begin
      errors++; $display("FAIL rstmid_first got %b exp %b", obs(), 9'b1_0000_0110);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_up_wrap();
    test_down();
    test_errors();
    test_hold_gaps();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_seq_monitor.md
Name: gray_seq_monitor

Overview:
Downstream consumer of the 4-bit binary-to-Gray converter stage. Takes a stream of Gray-coded samples and converts each back to binary through a 2-stage registered pipeline. It checks that consecutive accepted samples are legal single-step neighbours, reports direction and wrap-around, and keeps a saturating error count. Used as the self-checking sink for Gray-code sequences, both counters and converter output.

Parameters:
W, 4, Gray/binary data width in bits (W >= 2)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
g_valid  input  1  g_in carries a sample this cycle
g_in  input  W  Gray-coded sample
err_clr  input  1  synchronous clear of err_count
b_out  output  W  binary equivalent of the sample; holds the last value when b_valid=0
b_valid  output  1  one-cycle pulse: b_out and the step flags are valid
step_ok  output  1  pulse: sample is exactly +1 or -1 (mod 2^W) from the previous sample
step_err  output  1  pulse: sample is neither hold nor +/-1 from the previous sample
dir_up  output  1  pulse with step_ok: 1 = increment, 0 = decrement; 0 otherwise
wrap  output  1  pulse with step_ok: transition between 2^W-1 and 0 in either direction
err_count  output  ERR_CNT_W  number of step_err events, saturating at all-ones

Behaviour:
- Reset: one clock, synchronous, active-high. When rst=1 at a rising edge, every output goes to 0, both pipeline stages are invalidated and the FSM goes to FIRST. Reset outranks every other input.
- Stage 1: on g_valid=1, register g_in into g_r and set v1=1; otherwise v1=0. No backpressure; every valid sample is accepted.
- Stage 2: when v1=1, compute b_new: b[W-1]=g_r[W-1], and b[i]=b[i+1]^g_r[i] for i=W-2..0. Register b_new to b_out and pulse b_valid.
- Latency: the sample presented with g_valid in cycle N gives b_valid=1 in cycle N+2. Back-to-back samples give back-to-back b_valid pulses.
- FSM state FIRST (after reset): the first sample that reaches stage 2 produces b_valid=1 with step_ok=step_err=dir_up=wrap=0. It stores b_new into b_prev and moves the FSM to TRACK.
- FSM state TRACK: for each sample reaching stage 2, compute d = (b_new - b_prev) mod 2^W.
  - d=0 (hold): b_valid=1 only; no flags.
  - d=1: step_ok=1, dir_up=1, wrap=1 if b_prev=2^W-1.
  - d=2^W-1: step_ok=1, dir_up=0, wrap=1 if b_prev=0.
  - any other d: step_err=1, and err_count increments unless it is already all-ones.
  - b_prev <= b_new in every case, including an error, so checking resynchronises to the new sample.
- Gaps in g_valid do not change state. The next sample is compared against the last accepted sample.
- Flags are single-cycle pulses coincident with b_valid and are 0 in every other cycle.
- err_clr=1 sets err_count to 0 on that edge. If an error increment lands on the same edge, the clear wins and the result is 0. err_clr does not affect the FSM or pipeline.
- Reset mid-operation: in-flight samples in stage 1 or 2 are discarded and never produce b_valid. The next sample after reset is treated as FIRST.
- All arithmetic is modulo 2^W, unsigned.

Test Plan:
- Basic sequence: rst high for 2 cycles, then g_in = 0000, 0001, 0011, 0010 on 4 consecutive valid cycles -> b_out = 0, 1, 2, 3 on 4 consecutive cycles starting 2 cycles after the first valid. The first sample gives no flags; the next three give step_ok=1, dir_up=1, wrap=0.
- Up wrap: g_in 1000 (binary 15) then 0000 -> second sample gives step_ok=1, dir_up=1, wrap=1, b_out=0.
- Down steps: g_in 0000 then 1000 -> step_ok=1, dir_up=0, wrap=1, b_out=15. Then 0011 followed by 0001 (2 -> 1) -> step_err=1 for the 15->2 jump, then step_ok=1, dir_up=0, wrap=0.
- Errors: from a fresh reset, g_in 0001 (binary 1) then 1001 (binary 14) -> step_err=1, err_count=1. Drive 300 alternating illegal jumps -> err_count stops at 255. Assert err_clr together with an error -> err_count=0.
- Hold and gaps: g_in 0011 twice with 3 idle cycles between -> second sample gives b_valid=1, b_out=2, and no flag. Then 0110 (binary 4) -> step_err=1.
- Reset mid-stream: valid samples in cycles N and N+1 with rst=1 in cycle N+1 -> no b_valid pulse for either sample, err_count=0. The next sample (0101) gives b_valid with no flags and b_out=6.
